i2s_rx_stream: RTL
==================

# i2s_rx_stream

Parametrised I2S/left-justified serial audio receiver with a buffered valid/ready sample output. It samples the external `sck`/`ws`/`sd` pins in the system `clk` domain and assembles each slot into a `SAMPLE_WIDTH`-bit word tagged with its channel. Words enter a small FIFO, which overrun-protects the downstream visualiser/DSP pipeline. It replaces the fixed-width, register-only receiver at the front of the audio path.

## Interface
- `SAMPLE_WIDTH`, 24: bits captured per slot, MSB first (8..32).
- `SLOT_WIDTH`, 32: nominal bits per slot (≥ `SAMPLE_WIDTH`, ≤ 64); sizes the bit counter.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥ 2).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sck` in 1: serial bit clock, asynchronous to `clk`.
- `ws` in 1: word select, asynchronous (0 = left, 1 = right).
- `sd` in 1: serial data, asynchronous.
- `fmt` in 1: 0 = I2S (MSB one bit after `ws` edge), 1 = left-justified (MSB on `ws` edge). Quasi-static.
- `out_data` out `SAMPLE_WIDTH`: sample at FIFO head.
- `out_chan` out 1: channel of `out_data` (0 left, 1 right).
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts head when `out_valid & out_ready`.
- `overrun` out 1: sticky; a completed word was dropped because the FIFO was full.
- `overrun_clr` in 1: clears `overrun` (single-cycle pulse).
- `short_slot` out 1: sticky; a slot ended with fewer than `SAMPLE_WIDTH` bits. Cleared by `overrun_clr`.

## Operation
- Synchronisers: `sck`, `ws`, `sd` each pass through 2 flops. A third `sck` flop drives `sck_rise` (synced 1, previous 0). All serial activity happens only on `sck_rise` cycles. Falling edges are unused.
- On each `sck_rise`: capture `ws_s` into `ws_d`, then `ws_d` into `ws_dd`. `bnd = ws_d ^ ws_dd`.
- Effective slot select: `fmt=1` uses current `ws_s` vs `ws_d` (boundary on the edge where `ws` changes). `fmt=0` uses `ws_d` vs `ws_dd` (boundary one bit later).
- Bit counter `bitcnt` (width `$clog2(SLOT_WIDTH+1)`): at a boundary, the current bit is index 0 of the new slot. Otherwise `bitcnt` increments, saturating at `SLOT_WIDTH`.
- Shift register: bit index k < `SAMPLE_WIDTH` is written to position `SAMPLE_WIDTH-1-k`. Bits with k ≥ `SAMPLE_WIDTH` are ignored. The register is zeroed at each boundary before writing bit 0. A short slot therefore yields zero-padded LSBs and sets `short_slot`.
- Commit: at each boundary, the finished slot's word and channel (the slot-select level during that slot) are pushed to the FIFO.
- Sync state: after reset, or after a `fmt` change (detected by comparing with a registered copy), the block is unlocked. The first boundary only locks and commits nothing; the partial slot is discarded.
- FIFO push when full: the word is dropped, `overrun` is set, and existing contents are untouched.
- FIFO pop on `out_valid & out_ready`. Simultaneous push and pop when full is allowed: the pop frees space and the push succeeds.
- `overrun_clr` coincident with a new overrun: set wins.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_chan=0`, `overrun=0`, `short_slot=0`. FIFO empty, unlocked, `bitcnt=0`, shift register 0, sync flops 0.
- `rst` mid-slot: the partial word is discarded and the FIFO is flushed next cycle. The first post-reset boundary only relocks.
- Input requirement: each `sck` high and low phase ≥ 3 `clk` periods. Pin-to-`sck_rise` latency is 2–3 cycles.
- Commit latency: push happens in the cycle after the boundary `sck_rise` strobe. `out_valid` rises the following cycle if the FIFO was empty (strobe + 2).
- `out_data`/`out_chan` are stable while `out_valid & ~out_ready`. Head advances the cycle after a pop.
- FIFO occupancy 0..`FIFO_DEPTH`, with wrap-around pointers plus a count/extra bit. Full and empty are never ambiguous.

## Test plan
- I2S, `fmt=0`, `SAMPLE_WIDTH=24`, `SLOT_WIDTH=32`: send left 0xA5A5A5 then right 0x123456, each padded to 32 bits. Required: after lock, two pops yield (0xA5A5A5, chan 0) then (0x123456, chan 1). Flags stay 0.
- Left-justified, `fmt=1`: same frames with MSB aligned to the `ws` edge. Required: identical outputs. Re-running the I2S stream under `fmt=1` gives words shifted by one bit, proving mode distinction.
- Short slot: 16-bit slots carrying 0xBEEF. Required: `out_data=0xBEEF00` and `short_slot=1`.
- Overrun, `FIFO_DEPTH=4`, `out_ready=0`: send 6 words. Required: the first 4 are retained in order and `overrun=1`. Pulse `overrun_clr` → 0. Draining yields exactly 4 words.
- Backpressure and concurrency: hold the FIFO full, then assert `out_ready` on the exact push cycle. Required: no overrun, order preserved. Head stable while `out_ready=0`.
- Reset mid-slot and `fmt` toggle mid-stream: required is no output until a full subsequent slot. The first word after relock is correct, and the partial word is never emitted.

Source files
------------

// File: rtl/i2s_rx_stream.sv
// i2s_rx_stream: I2S / left-justified serial audio receiver. Samples the
// sck/ws/sd pins in the clk domain, assembles each slot into a channel-tagged
// word and buffers the words in a small valid/ready output FIFO.
module i2s_rx_stream #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck,
    input  logic                    ws,
    input  logic                    sd,
    input  logic                    fmt,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic                    out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    short_slot
);

    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SAMPLE_WIDTH-1:0] MSB_ONEHOT = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;

    // Pin synchronisers and edge detect
    logic sck_s1, sck_s2, sck_s3;
    logic ws_s1, ws_s;
    logic sd_s1, sd_s;
    logic sck_rise;

    // Slot tracking
    logic                    ws_d, ws_dd;
    logic                    slot_edge;
    logic                    slot_sel;
    logic                    cur_chan;
    logic [CW-1:0]           bitcnt;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] bit_mask;

    // Lock state
    lock_t state, state_next;
    logic  fmt_q;
    logic  commit;

    // Commit stage
    logic                    commit_pend;
    logic [SAMPLE_WIDTH-1:0] commit_word;
    logic                    commit_chan;

    // FIFO
    logic [SAMPLE_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  push, pop;

    assign sck_rise = sck_s2 & ~sck_s3;

    // Two-flop synchronisers plus a third sck flop for rising-edge detection
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all flops sample
        // the pre-edge values; blocking here would collapse the sync chain.
        if (rst) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            ws_s1  <= 1'b0;
            ws_s   <= 1'b0;
            sd_s1  <= 1'b0;
            sd_s   <= 1'b0;
        end else begin
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            ws_s1  <= ws;
            ws_s   <= ws_s1;
            sd_s1  <= sd;
            sd_s   <= sd_s1;
        end
    end

    // Slot boundary and slot-select level for the active format
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        slot_edge = 1'b0;
        slot_sel  = 1'b0;
        if (fmt) begin
            slot_edge = ws_s ^ ws_d;
            slot_sel  = ws_s;
        end else begin
            slot_edge = ws_d ^ ws_dd;
            slot_sel  = ws_d;
        end
    end

    // Per-bit serial datapath: ws history, bit counter, MSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_d      <= 1'b0;
            ws_dd     <= 1'b0;
            cur_chan  <= 1'b0;
            bitcnt    <= '0;
            shift_reg <= '0;
            bit_mask  <= MSB_ONEHOT;
        end else if (sck_rise) begin
            ws_d  <= ws_s;
            ws_dd <= ws_d;
            if (slot_edge) begin
                // Current bit is index 0 of the new slot: lands in the MSB.
                cur_chan  <= slot_sel;
                bitcnt    <= CW'(1);
                shift_reg <= MSB_ONEHOT & {SAMPLE_WIDTH{sd_s}};
                bit_mask  <= MSB_ONEHOT >> 1;
            end else begin
                if (bitcnt != CW'(SLOT_WIDTH))
                    bitcnt <= bitcnt + CW'(1);
                // Mask runs out after SAMPLE_WIDTH bits, so padding bits are ignored.
                shift_reg <= (shift_reg & ~bit_mask) | (bit_mask & {SAMPLE_WIDTH{sd_s}});
                bit_mask  <= bit_mask >> 1;
            end
        end
    end

    // Registered copy of fmt, used to detect a mode change
    always_ff @(posedge clk) begin
        fmt_q <= fmt;
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= UNLOCKED;
        else
            state <= state_next;
    end

    // Lock next-state: first boundary only locks, later boundaries commit
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        if (fmt != fmt_q) begin
            state_next = UNLOCKED;
        end else if (sck_rise && slot_edge) begin
            if (state == UNLOCKED)
                state_next = LOCKED;
            else
                commit = 1'b1;
        end
    end

    // Commit stage: hold the finished word for one cycle before the FIFO push
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_pend <= 1'b0;
            commit_word <= '0;
            commit_chan <= 1'b0;
        end else begin
            commit_pend <= commit;
            if (commit) begin
                commit_word <= shift_reg;
                commit_chan <= cur_chan;
            end
        end
    end

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = commit_pend & (~full | pop);

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gates every read,
        // so stale contents are never visible.
        if (push)
            mem[wr_ptr] <= {commit_chan, commit_word};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_data = out_valid ? mem[rd_ptr][SAMPLE_WIDTH-1:0] : '0;
    assign out_chan = out_valid ? mem[rd_ptr][SAMPLE_WIDTH] : 1'b0;

    // Sticky status flags; a new event wins over a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            short_slot <= 1'b0;
        end else begin
            if (commit_pend && !push)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            if (commit && (bitcnt < CW'(SAMPLE_WIDTH)))
                short_slot <= 1'b1;
            else if (overrun_clr)
                short_slot <= 1'b0;
        end
    end

endmodule
